// File: rtl/regfile_arbiter.sv
// ----------------------------------------------------------------------------
// regfile_arbiter
//
// Sits in front of the 32x32 register file and owns its write port and first
// read port. After reset it sweeps every register to zero, then shares the
// ports between two requesters with a round-robin arbiter. It grants at most
// one access per cycle. Requester writes to address 0 are accepted but never
// reach the register file, so x0 reads back as zero.
//
// Ports
//   CLK, RST_n                 clock, asynchronous active-low reset
//   ReqValid0/1, ReqWrite0/1   request present / 1 = write, 0 = read
//   ReqAddr0/1, ReqWData0/1    register address / write data
//   ReqReady0/1                request accepted this cycle (combinational)
//   RspValid0/1, RspData       read response one cycle after accept
//   InitDone                   high once the zero sweep has finished
//   RfReadAddress              register file first read address
//   RfWriteAddress             register file write address
//   RfWriteData, RfWriteEn     register file write data / enable
//   RfReadData                 register file first read data (registered)
// ----------------------------------------------------------------------------
module regfile_arbiter #(
    parameter int NUM_REGS    = 32,
    parameter int ADDR_W      = 5,
    parameter int DATA_W      = 32,
    parameter int INIT_ENABLE = 1
) (
    input  logic              CLK,
    input  logic              RST_n,

    input  logic              ReqValid0,
    input  logic              ReqWrite0,
    input  logic [ADDR_W-1:0] ReqAddr0,
    input  logic [DATA_W-1:0] ReqWData0,
    output logic              ReqReady0,

    input  logic              ReqValid1,
    input  logic              ReqWrite1,
    input  logic [ADDR_W-1:0] ReqAddr1,
    input  logic [DATA_W-1:0] ReqWData1,
    output logic              ReqReady1,

    output logic              RspValid0,
    output logic              RspValid1,
    output logic [DATA_W-1:0] RspData,
    output logic              InitDone,

    output logic [ADDR_W-1:0] RfReadAddress,
    output logic [ADDR_W-1:0] RfWriteAddress,
    output logic [DATA_W-1:0] RfWriteData,
    output logic              RfWriteEn,
    input  logic [DATA_W-1:0] RfReadData
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam state_e            RESET_STATE = (INIT_ENABLE != 0) ? ST_INIT : ST_RUN;
    localparam logic [ADDR_W-1:0] LAST_IDX    = ADDR_W'(NUM_REGS - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e            state_q,      state_d;
    logic [ADDR_W-1:0] init_cnt_q,   init_cnt_d;
    logic              last_grant_q, last_grant_d;
    logic              rsp_valid0_q, rsp_valid0_d;
    logic              rsp_valid1_q, rsp_valid1_d;
    logic [ADDR_W-1:0] rd_addr_q,    rd_addr_d;
    logic [ADDR_W-1:0] wr_addr_q,    wr_addr_d;

    // ------------------------------------------------------------------
    // Combinational internals
    // ------------------------------------------------------------------
    logic              run;
    logic              sweeping;
    logic              grant0;
    logic              grant1;
    logic              sel_write;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [ADDR_W-1:0] rf_read_addr;
    logic [ADDR_W-1:0] rf_write_addr;
    logic [DATA_W-1:0] rf_write_data;
    logic              rf_write_en;

    assign run      = (state_q == ST_RUN);
    assign sweeping = (state_q == ST_INIT);

    // Round-robin: with both valid, the requester that did not win last time
    // is granted. last_grant_q = 1 means requester 1 won last, so 0 goes next.
    assign grant0 = run && ReqValid0 && (!ReqValid1 ||  last_grant_q);
    assign grant1 = run && ReqValid1 && (!ReqValid0 || !last_grant_q);

    assign sel_write = grant1 ? ReqWrite1 : ReqWrite0;
    assign sel_addr  = grant1 ? ReqAddr1  : ReqAddr0;
    assign sel_wdata = grant1 ? ReqWData1 : ReqWData0;

    // Register file port drive. Addresses hold their previous value whenever
    // the port is idle so the register file inputs do not toggle needlessly.
    always_comb begin
        rf_read_addr  = rd_addr_q;
        rf_write_addr = wr_addr_q;
        rf_write_data = '0;
        rf_write_en   = 1'b0;

        if (sweeping) begin
            rf_write_addr = init_cnt_q;
            rf_write_data = '0;
            rf_write_en   = 1'b1;
        end else if (grant0 || grant1) begin
            if (sel_write) begin
                rf_write_addr = sel_addr;
                rf_write_data = sel_wdata;
                // x0 is hardwired: accept the write but never commit it.
                rf_write_en   = (sel_addr != '0);
            end else begin
                rf_read_addr  = sel_addr;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        init_cnt_d   = init_cnt_q;
        last_grant_d = last_grant_q;
        rsp_valid0_d = 1'b0;
        rsp_valid1_d = 1'b0;
        rd_addr_d    = rf_read_addr;
        wr_addr_d    = rf_write_addr;

        case (state_q)
            ST_INIT: begin
                if (init_cnt_q == LAST_IDX) begin
                    state_d    = ST_RUN;
                    init_cnt_d = '0;
                end else begin
                    init_cnt_d = init_cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                // RUN is only left through reset.
            end
            default: begin
                state_d = RESET_STATE;
            end
        endcase

        if (grant0) begin
            last_grant_d = 1'b0;
        end else if (grant1) begin
            last_grant_d = 1'b1;
        end

        // The register file registers its read data, so a read accepted now
        // is answered next cycle straight from RfReadData.
        rsp_valid0_d = grant0 && !ReqWrite0;
        rsp_valid1_d = grant1 && !ReqWrite1;
    end

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q      <= RESET_STATE;
            init_cnt_q   <= '0;
            last_grant_q <= 1'b1;
            rsp_valid0_q <= 1'b0;
            rsp_valid1_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            init_cnt_q   <= init_cnt_d;
            last_grant_q <= last_grant_d;
            rsp_valid0_q <= rsp_valid0_d;
            rsp_valid1_q <= rsp_valid1_d;
        end
    end

    // Address hold registers carry only don't-care values, so no reset.
    always_ff @(posedge CLK) begin
        rd_addr_q <= rd_addr_d;
        wr_addr_q <= wr_addr_d;
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Enables and status are forced low while reset is held, which matters
    // when the reset state is RUN or INIT (both would otherwise drive them).
    assign ReqReady0      = grant0 && RST_n;
    assign ReqReady1      = grant1 && RST_n;
    assign RfWriteEn      = rf_write_en && RST_n;
    assign InitDone       = run && RST_n;
    assign RfReadAddress  = rf_read_addr;
    assign RfWriteAddress = rf_write_addr;
    assign RfWriteData    = rf_write_data;
    assign RspValid0      = rsp_valid0_q;
    assign RspValid1      = rsp_valid1_q;
    assign RspData        = RfReadData;

endmodule

// File: tb/tb_regfile_arbiter.sv
// ----------------------------------------------------------------------------
// tb_regfile_arbiter
//
// Bench for regfile_arbiter. A small register file stub answers the read
// port; a transaction-level reference model (sweep counter, last-winner
// integer, register array and next-cycle response slot) predicts every
// output of each cycle.
// ----------------------------------------------------------------------------
module tb_regfile_arbiter;

    localparam int NUM_REGS    = 32;
    localparam int ADDR_W      = 5;
    localparam int DATA_W      = 32;
    localparam int INIT_ENABLE = 1;

    logic              CLK;
    logic              RST_n;
    logic              ReqValid0, ReqWrite0, ReqReady0;
    logic [ADDR_W-1:0] ReqAddr0;
    logic [DATA_W-1:0] ReqWData0;
    logic              ReqValid1, ReqWrite1, ReqReady1;
    logic [ADDR_W-1:0] ReqAddr1;
    logic [DATA_W-1:0] ReqWData1;
    logic              RspValid0, RspValid1;
    logic [DATA_W-1:0] RspData;
    logic              InitDone;
    logic [ADDR_W-1:0] RfReadAddress, RfWriteAddress;
    logic [DATA_W-1:0] RfWriteData;
    logic              RfWriteEn;
    logic [DATA_W-1:0] RfReadData;

    regfile_arbiter #(
        .NUM_REGS    (NUM_REGS),
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .INIT_ENABLE (INIT_ENABLE)
    ) dut (
        .CLK            (CLK),
        .RST_n          (RST_n),
        .ReqValid0      (ReqValid0),
        .ReqWrite0      (ReqWrite0),
        .ReqAddr0       (ReqAddr0),
        .ReqWData0      (ReqWData0),
        .ReqReady0      (ReqReady0),
        .ReqValid1      (ReqValid1),
        .ReqWrite1      (ReqWrite1),
        .ReqAddr1       (ReqAddr1),
        .ReqWData1      (ReqWData1),
        .ReqReady1      (ReqReady1),
        .RspValid0      (RspValid0),
        .RspValid1      (RspValid1),
        .RspData        (RspData),
        .InitDone       (InitDone),
        .RfReadAddress  (RfReadAddress),
        .RfWriteAddress (RfWriteAddress),
        .RfWriteData    (RfWriteData),
        .RfWriteEn      (RfWriteEn),
        .RfReadData     (RfReadData)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Register file stub: write committed at the edge, read data registered.
    logic [DATA_W-1:0] rf_mem [NUM_REGS];
    always @(posedge CLK) begin
        if (RfWriteEn) rf_mem[RfWriteAddress] <= RfWriteData;
        RfReadData <= rf_mem[RfReadAddress];
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model state
    int                m_cyc;
    int                m_last;
    logic [DATA_W-1:0] m_mem [NUM_REGS];
    logic              m_rv0, m_rv1;
    logic [DATA_W-1:0] m_rd;

    task automatic model_reset();
        m_cyc  = 0;
        m_last = 1;
        m_rv0  = 1'b0;
        m_rv1  = 1'b0;
        m_rd   = '0;
    endtask

    // One clock cycle: drive requests, compare every output with the model,
    // then advance the model as the clock edge will. g returns the grant.
    task automatic cycle(input logic v0, input logic w0, input logic [ADDR_W-1:0] a0,
                         input logic [DATA_W-1:0] d0,
                         input logic v1, input logic w1, input logic [ADDR_W-1:0] a1,
                         input logic [DATA_W-1:0] d1, output int g);
        logic              init;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        @(negedge CLK);
        ReqValid0 = v0; ReqWrite0 = w0; ReqAddr0 = a0; ReqWData0 = d0;
        ReqValid1 = v1; ReqWrite1 = w1; ReqAddr1 = a1; ReqWData1 = d1;
        #1;
        check("rsp_valid0", 32'(RspValid0), 32'(m_rv0));
        check("rsp_valid1", 32'(RspValid1), 32'(m_rv1));
        if (m_rv0 || m_rv1) check("rsp_data", RspData, m_rd);

        init = (INIT_ENABLE != 0) && (m_cyc < NUM_REGS);
        check("init_done", 32'(InitDone), 32'(!init));

        g = -1;
        if (!init) begin
            if (v0 && v1)  g = 1 - m_last;
            else if (v0)   g = 0;
            else if (v1)   g = 1;
        end
        check("ready0", 32'(ReqReady0), 32'(g == 0));
        check("ready1", 32'(ReqReady1), 32'(g == 1));

        m_rv0 = 1'b0;
        m_rv1 = 1'b0;
        if (init) begin
            check("sweep_we",   32'(RfWriteEn),      32'd1);
            check("sweep_addr", 32'(RfWriteAddress), 32'(m_cyc));
            check("sweep_data", RfWriteData,         32'd0);
            m_mem[ADDR_W'(m_cyc)] = '0;
        end else if (g < 0) begin
            check("idle_we", 32'(RfWriteEn), 32'd0);
        end else begin
            wr   = (g == 1) ? w1 : w0;
            addr = (g == 1) ? a1 : a0;
            data = (g == 1) ? d1 : d0;
            if (wr) begin
                check("wr_en",   32'(RfWriteEn),      32'(addr != 0));
                check("wr_addr", 32'(RfWriteAddress), 32'(addr));
                check("wr_data", RfWriteData,         data);
                if (addr != 0) m_mem[addr] = data;
            end else begin
                check("rd_we",   32'(RfWriteEn),     32'd0);
                check("rd_addr", 32'(RfReadAddress), 32'(addr));
                if (g == 0) m_rv0 = 1'b1; else m_rv1 = 1'b1;
                m_rd = m_mem[addr];
            end
            m_last = g;
        end
        m_cyc++;
    endtask

    task automatic idle(input int n);
        int g;
        for (int i = 0; i < n; i++) cycle(0, 0, '0, '0, 0, 0, '0, '0, g);
    endtask

    // Randomized requesters that hold their request until granted.
    logic              p0v, p0w, p1v, p1w;
    logic [ADDR_W-1:0] p0a, p1a;
    logic [DATA_W-1:0] p0d, p1d;

    task automatic random_run(input int n);
        int g;
        for (int i = 0; i < n; i++) begin
            if (!p0v && $urandom_range(0, 9) < 6) begin
                p0v = 1'b1; p0w = 1'($urandom_range(0, 1));
                p0a = ($urandom_range(0, 7) == 0) ? '0 : ADDR_W'($urandom_range(0, NUM_REGS-1));
                p0d = $urandom;
            end
            if (!p1v && $urandom_range(0, 9) < 6) begin
                p1v = 1'b1; p1w = 1'($urandom_range(0, 1));
                p1a = ($urandom_range(0, 7) == 0) ? '0 : ADDR_W'($urandom_range(0, NUM_REGS-1));
                p1d = $urandom;
            end
            cycle(p0v, p0w, p0a, p0d, p1v, p1w, p1a, p1d, g);
            if (g == 0) p0v = 1'b0;
            if (g == 1) p1v = 1'b0;
        end
    endtask

    initial begin
        int g;
        RST_n = 1'b0;
        ReqValid0 = 0; ReqWrite0 = 0; ReqAddr0 = '0; ReqWData0 = '0;
        ReqValid1 = 0; ReqWrite1 = 0; ReqAddr1 = '0; ReqWData1 = '0;
        p0v = 0; p0w = 0; p0a = '0; p0d = '0;
        p1v = 0; p1w = 0; p1a = '0; p1d = '0;
        for (int i = 0; i < NUM_REGS; i++) m_mem[i] = 32'hBAD0_0000 + 32'(i);
        model_reset();

        // Reset state, with a request pending to show readies stay low
        ReqValid0 = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_we",     32'(RfWriteEn), 32'd0);
        check("rst_ready0", 32'(ReqReady0), 32'd0);
        check("rst_done",   32'(InitDone),  32'd0);
        check("rst_rsp0",   32'(RspValid0), 32'd0);
        check("rst_rsp1",   32'(RspValid1), 32'd0);
        ReqValid0 = 1'b0;
        @(posedge CLK); #2; RST_n = 1'b1;

        // Sweep plus a couple of idle RUN cycles
        idle(NUM_REGS + 2);

        // Write then read x5 on requester 0
        cycle(1, 1, 5'd5, 32'hDEADBEEF, 0, 0, '0, '0, g);
        cycle(1, 0, 5'd5, '0,           0, 0, '0, '0, g);
        idle(1);

        // Both valid for 6 cycles, each reading its own register
        cycle(0, 1, '0, '0, 1, 1, 5'd7, 32'h0000_7777, g);
        repeat (6) cycle(1, 0, 5'd5, '0, 1, 0, 5'd7, '0, g);
        idle(1);

        // Write to x0 from requester 1 is accepted but suppressed
        cycle(0, 0, '0, '0, 1, 1, 5'd0, 32'h12345678, g);
        cycle(0, 0, '0, '0, 1, 0, 5'd0, '0, g);
        idle(1);

        // Requester 1 alone for 3 cycles, then contention
        repeat (3) cycle(0, 0, '0, '0, 1, 0, 5'd7, '0, g);
        cycle(1, 0, 5'd5, '0, 1, 0, 5'd7, '0, g);
        check("contention_winner", 32'(g), 32'd0);
        cycle(0, 0, '0, '0, 1, 0, 5'd7, '0, g);
        idle(1);

        random_run(400);

        // Reset just after a read accept: the response must never appear
        idle(1);
        p0v = 0; p1v = 0;
        cycle(1, 0, 5'd5, '0, 0, 0, '0, '0, g);
        RST_n = 1'b0;
        @(negedge CLK); #1;
        check("mid_rst_rsp0",  32'(RspValid0), 32'd0);
        check("mid_rst_done",  32'(InitDone),  32'd0);
        check("mid_rst_we",    32'(RfWriteEn), 32'd0);
        check("mid_rst_ready", 32'(ReqReady0), 32'd0);
        @(posedge CLK); #2; RST_n = 1'b1;
        model_reset();
        idle(NUM_REGS + 1);
        random_run(150);
        idle(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
